// File: rtl/systolic_matmul_engine.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier: Z = A*B (signed),
// with internal operand skewing, K-tile accumulation and N-bit output saturation.
module systolic_matmul_engine #(
  parameter int N     = 16,
  parameter int SIZE  = 4,
  parameter int ACC_W = 2*N+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   acc_en,
  input  logic [N*SIZE*SIZE-1:0] A,
  input  logic [N*SIZE*SIZE-1:0] B,
  output logic [N*SIZE*SIZE-1:0] Z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag
);

  localparam int LAST = 3*SIZE-2;
  localparam int CW   = $clog2(LAST+1);
  localparam int TW   = N*SIZE*SIZE;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FEED, HOLD} state_t;

  state_t                   state, state_next;
  logic [CW-1:0]            step;
  logic [TW-1:0]            a_q, b_q;
  logic signed [N-1:0]      a_el   [SIZE][SIZE];
  logic signed [N-1:0]      b_el   [SIZE][SIZE];
  logic signed [N-1:0]      a_pipe [SIZE][SIZE];
  logic signed [N-1:0]      b_pipe [SIZE][SIZE];
  logic signed [N-1:0]      a_in   [SIZE][SIZE];
  logic signed [N-1:0]      b_in   [SIZE][SIZE];
  logic signed [2*N-1:0]    prod   [SIZE][SIZE];
  logic signed [ACC_W-1:0]  acc    [SIZE][SIZE];
  logic [TW-1:0]            z_sat;
  logic                     sat_any;
  logic                     accept, feed_done;

  assign accept    = in_valid && in_ready;
  assign feed_done = (state == FEED) && (step == CW'(LAST));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = FEED;
      FEED:    if (feed_done) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == HOLD);
  end

  // Edge injection: row i / column j receive element k at step k+i / k+j.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      for (int unsigned j = 0; j < SIZE; j++) begin
        a_el[i][j] = a_q[(i*SIZE+j)*N +: N];
        b_el[i][j] = b_q[(i*SIZE+j)*N +: N];
      end
    end
    for (int unsigned i = 0; i < SIZE; i++) begin
      for (int unsigned j = 0; j < SIZE; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
        if (j == 0) begin
          for (int unsigned k = 0; k < SIZE; k++)
            if (32'(step) == i + k) a_in[i][j] = a_el[i][k];
        end else begin
          a_in[i][j] = a_pipe[i][j-1];
        end
        if (i == 0) begin
          for (int unsigned k = 0; k < SIZE; k++)
            if (32'(step) == k + j) b_in[i][j] = b_el[k][j];
        end else begin
          b_in[i][j] = b_pipe[i-1][j];
        end
        prod[i][j] = a_in[i][j] * b_in[i][j];
      end
    end
  end

  always_comb begin
    z_sat   = '0;
    sat_any = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      for (int unsigned j = 0; j < SIZE; j++) begin
        if (acc[i][j] > MAXV) begin
          z_sat[(i*SIZE+j)*N +: N] = MAXV[N-1:0];
          sat_any = 1'b1;
        end else if (acc[i][j] < MINV) begin
          z_sat[(i*SIZE+j)*N +: N] = MINV[N-1:0];
          sat_any = 1'b1;
        end else begin
          z_sat[(i*SIZE+j)*N +: N] = acc[i][j][N-1:0];
        end
      end
    end
  end

  // FEED runs one drain step past the last MAC step; every operand reaching a PE
  // then is zero, so Z is captured from settled accumulators 3*SIZE-1 cycles in.
  always_ff @(posedge clk) begin
    if (reset) begin
      step     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      Z        <= '0;
      sat_flag <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        for (int unsigned j = 0; j < SIZE; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
      end
    end else begin
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        step <= '0;
        if (!acc_en)
          for (int unsigned i = 0; i < SIZE; i++)
            for (int unsigned j = 0; j < SIZE; j++)
              acc[i][j] <= '0;
      end
      if (state == FEED) begin
        if (!feed_done) step <= step + 1'b1;
        for (int unsigned i = 0; i < SIZE; i++) begin
          for (int unsigned j = 0; j < SIZE; j++) begin
            a_pipe[i][j] <= a_in[i][j];
            b_pipe[i][j] <= b_in[i][j];
            acc[i][j]    <= acc[i][j] + ACC_W'(prod[i][j]);
          end
        end
      end
      if (feed_done) begin
        Z        <= z_sat;
        sat_flag <= sat_any;
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboarded bench for systolic_matmul_engine at SIZE=4/N=16 and SIZE=2/N=8.
module tb_systolic_matmul_engine;

  typedef struct {
    logic [255:0] z;
    bit           sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic iv4 = 1'b0, ae4 = 1'b0, or4 = 1'b0, ir4, ov4, s4;
  logic [255:0] A4 = '0, B4 = '0, Z4;
  logic iv2 = 1'b0, ae2 = 1'b0, or2 = 1'b0, ir2, ov2, s2;
  logic [31:0] A2 = '0, B2 = '0, Z2;

  int checks = 0;
  int errors = 0;
  exp_t sb4[$];
  exp_t sb2[$];
  longint macc[2][16];

  always #5 clk = ~clk;

  systolic_matmul_engine #(.N(16), .SIZE(4), .ACC_W(36)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .acc_en(ae4),
    .A(A4), .B(B4), .Z(Z4), .out_valid(ov4), .out_ready(or4), .sat_flag(s4));

  systolic_matmul_engine #(.N(8), .SIZE(2), .ACC_W(20)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .acc_en(ae2),
    .A(A2), .B(B2), .Z(Z2), .out_valid(ov2), .out_ready(or2), .sat_flag(s2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint elt(input logic [255:0] v, input int n, input int idx);
    logic [255:0] t;
    t = v >> (idx*n);
    if (n == 8) return longint'($signed(t[7:0]));
    return longint'($signed(t[15:0]));
  endfunction

  function automatic void model(input int inst, input logic [255:0] a, input logic [255:0] b,
                                input bit en, output logic [255:0] z, output bit sat);
    int n, sz, aw, e;
    longint maxv, minv, sum, v;
    logic [15:0] lo;
    n = inst ? 8 : 16;
    sz = inst ? 2 : 4;
    aw = 2*n + 4;
    maxv = (longint'(1) <<< (n-1)) - 1;
    minv = -maxv - 1;
    z = '0;
    sat = 1'b0;
    for (int i = 0; i < sz; i++) begin
      for (int j = 0; j < sz; j++) begin
        e = i*sz + j;
        sum = 0;
        for (int k = 0; k < sz; k++) sum += elt(a, n, i*sz+k) * elt(b, n, k*sz+j);
        if (!en) macc[inst][e] = 0;
        v = macc[inst][e] + sum;
        v = (v <<< (64-aw)) >>> (64-aw);
        macc[inst][e] = v;
        if (v > maxv) begin v = maxv; sat = 1'b1; end
        else if (v < minv) begin v = minv; sat = 1'b1; end
        lo = v[15:0];
        if (n == 8) lo[15:8] = 8'h00;
        z = z | (256'(lo) << (e*n));
      end
    end
  endfunction

  task automatic send(input int inst, input logic [255:0] a, input logic [255:0] b, input bit en);
    exp_t e;
    int w;
    w = 0;
    while (!(inst ? ir2 : ir4) && w < 60) begin tick(); w++; end
    checks++;
    if (w >= 60) begin
      errors++;
      $display("FAIL send_ready inst=%0d: in_ready=0, required 1 within 60 cycles", inst);
      return;
    end
    model(inst, a, b, en, e.z, e.sat);
    if (inst != 0) begin
      sb2.push_back(e); iv2 = 1'b1; A2 = a[31:0]; B2 = b[31:0]; ae2 = en;
    end else begin
      sb4.push_back(e); iv4 = 1'b1; A4 = a; B4 = b; ae4 = en;
    end
    tick();
    iv2 = 1'b0; iv4 = 1'b0; ae2 = 1'b0; ae4 = 1'b0;
  endtask

  task automatic wait_out(input int inst, input bit rnd, output int lat);
    lat = 0;
    do begin
      if (rnd) begin
        if (inst != 0) or2 = 1'($urandom_range(0, 1));
        else           or4 = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end while (!(inst ? ov2 : ov4) && lat < 60);
    if (!(inst ? ov2 : ov4)) lat = -1;
  endtask

  task automatic handshake(input int inst, input bit rnd, output bit ok);
    bit hr;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      hr = inst ? or2 : or4;
      tick();
      if (hr) ok = 1'b1;
      else begin
        hr = (c >= 4 || !rnd) ? 1'b1 : 1'($urandom_range(0, 1));
        if (inst != 0) or2 = hr; else or4 = hr;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iv4 = 1'b1; A4 = {8{$urandom()}}; iv2 = 1'b1;
    tick();
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL reset_ready4: got %b want 0", ir4); end
    checks++; if (ir2 !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b want 0", ir2); end
    reset = 1'b0; iv4 = 1'b0; iv2 = 1'b0;
    for (int e = 0; e < 16; e++) begin macc[0][e] = 0; macc[1][e] = 0; end
    #1;
    checks++; if ({ir4, ov4, s4} !== 3'b100) begin errors++; $display("FAIL reset_ctl4: got %b want 100", {ir4, ov4, s4}); end
    checks++; if (Z4 !== '0) begin errors++; $display("FAIL reset_z4: got %h want 0", Z4); end
    checks++; if ({ir2, ov2, s2, Z2} !== {3'b100, 32'h0}) begin errors++; $display("FAIL reset_2: got %b %h want 100 0", {ir2, ov2, s2}, Z2); end
    repeat (3) tick();
    checks++; if ({ir4, ov4} !== 2'b10) begin errors++; $display("FAIL reset_no_accept: got %b want 10", {ir4, ov4}); end
  endtask

  task automatic test_identity();
    logic [255:0] a, b;
    exp_t e;
    int lat;
    bit ok;
    a = '0; b = '0;
    for (int i = 0; i < 4; i++) a[(i*4+i)*16 +: 16] = 16'd1;
    for (int k = 0; k < 16; k++) b[k*16 +: 16] = 16'(k+1);
    or4 = 1'b1;
    send(0, a, b, 1'b0);
    wait_out(0, 1'b0, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL ident_latency: got %0d want 11", lat); end
    e = sb4.pop_front();
    checks++; if (Z4 !== e.z) begin errors++; $display("FAIL ident_z_model: got %h want %h", Z4, e.z); end
    checks++; if (Z4 !== b) begin errors++; $display("FAIL ident_z_eq_b: got %h want %h", Z4, b); end
    checks++; if (s4 !== 1'b0) begin errors++; $display("FAIL ident_sat: got %b want 0", s4); end
    handshake(0, 1'b0, ok);
    checks++; if (!ok || {ov4, ir4} !== 2'b01) begin errors++; $display("FAIL ident_release: ok=%b ov/ir=%b want 1 01", ok, {ov4, ir4}); end
  endtask

  task automatic test_saturation();
    exp_t e;
    int lat;
    bit ok;
    logic [255:0] want [2];
    want[0] = {16{16'h7FFF}};
    want[1] = {16{16'h8000}};
    for (int t = 0; t < 2; t++) begin
      or4 = 1'b1;
      send(0, want[t], {16{16'h7FFF}}, 1'b0);
      wait_out(0, 1'b0, lat);
      e = sb4.pop_front();
      checks++; if (Z4 !== want[t] || Z4 !== e.z) begin errors++; $display("FAIL sat_z%0d: got %h want %h", t, Z4, want[t]); end
      checks++; if (s4 !== 1'b1 || e.sat !== 1'b1) begin errors++; $display("FAIL sat_flag%0d: got %b want 1", t, s4); end
      handshake(0, 1'b0, ok);
    end
  endtask

  task automatic test_accumulate();
    exp_t e;
    int lat;
    bit ok;
    bit en [3];
    logic [15:0] v [3];
    en[0] = 1'b0; en[1] = 1'b1; en[2] = 1'b0;
    v[0] = 16'd4; v[1] = 16'd8; v[2] = 16'd4;
    for (int t = 0; t < 3; t++) begin
      or4 = 1'b1;
      send(0, {16{16'd1}}, {16{16'd1}}, en[t]);
      wait_out(0, 1'b0, lat);
      e = sb4.pop_front();
      checks++; if (Z4 !== {16{v[t]}} || Z4 !== e.z) begin errors++; $display("FAIL accum_tile%0d: got %h want %h", t, Z4, {16{v[t]}}); end
      checks++; if (s4 !== 1'b0) begin errors++; $display("FAIL accum_sat%0d: got %b want 0", t, s4); end
      handshake(0, 1'b0, ok);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    or4 = 1'b0;
    send(0, {8{$urandom()}}, {8{$urandom()}}, 1'b0);
    wait_out(0, 1'b0, lat);
    e = sb4.pop_front();
    checks++; if (lat != 11) begin errors++; $display("FAIL bp_latency: got %0d want 11", lat); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin iv4 = 1'b1; A4 = {8{$urandom()}}; ae4 = 1'b0; end
      tick();
      iv4 = 1'b0;
      checks++;
      if (Z4 !== e.z || s4 !== e.sat || ov4 !== 1'b1 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got z=%h sat=%b ov=%b ir=%b want z=%h sat=%b ov=1 ir=0", c, Z4, s4, ov4, ir4, e.z, e.sat);
      end
    end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    checks++; if ({ov4, ir4} !== 2'b01) begin errors++; $display("FAIL bp_release: got ov/ir=%b want 01", {ov4, ir4}); end
    repeat (3) tick();
    checks++; if ({ov4, ir4} !== 2'b01) begin errors++; $display("FAIL bp_ignored_pulse: got ov/ir=%b want 01", {ov4, ir4}); end
  endtask

  task automatic test_reset_midfeed();
    exp_t e;
    int lat;
    bit ok;
    logic [255:0] a;
    send(0, {8{$urandom()}}, {8{$urandom()}}, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    void'(sb4.pop_back());
    for (int k = 0; k < 16; k++) begin macc[0][k] = 0; macc[1][k] = 0; end
    checks++; if ({ov4, ir4} !== 2'b01 || Z4 !== '0) begin errors++; $display("FAIL midfeed_reset: got ov/ir=%b z=%h want 01 0", {ov4, ir4}, Z4); end
    a = '0;
    for (int i = 0; i < 4; i++) a[(i*4+i)*16 +: 16] = 16'd1;
    or4 = 1'b1;
    send(0, a, {16{16'd3}}, 1'b1);
    wait_out(0, 1'b0, lat);
    e = sb4.pop_front();
    checks++; if (lat != 11) begin errors++; $display("FAIL midfeed_latency: got %0d want 11", lat); end
    checks++; if (Z4 !== {16{16'd3}} || Z4 !== e.z) begin errors++; $display("FAIL midfeed_residue: got %h want %h", Z4, {16{16'd3}}); end
    handshake(0, 1'b0, ok);
  endtask

  task automatic test_back_to_back(input int inst, input int ntiles);
    exp_t e;
    int lat, want_lat;
    bit ok;
    logic [255:0] a, b, zc;
    want_lat = inst ? 5 : 11;
    for (int t = 0; t < ntiles; t++) begin
      a = {8{$urandom()}};
      b = {8{$urandom()}};
      if (inst != 0) begin a = {224'h0, a[31:0]}; b = {224'h0, b[31:0]}; end
      send(inst, a, b, (t > 0) && ($urandom_range(0, 2) == 0));
      wait_out(inst, 1'b1, lat);
      e = (inst != 0) ? sb2.pop_front() : sb4.pop_front();
      zc = (inst != 0) ? {224'h0, Z2} : Z4;
      checks++; if (lat != want_lat) begin errors++; $display("FAIL b2b_latency inst=%0d tile=%0d: got %0d want %0d", inst, t, lat, want_lat); end
      checks++; if (zc !== e.z) begin errors++; $display("FAIL b2b_z inst=%0d tile=%0d: got %h want %h", inst, t, zc, e.z); end
      checks++; if ((inst ? s2 : s4) !== e.sat) begin errors++; $display("FAIL b2b_sat inst=%0d tile=%0d: got %b want %b", inst, t, inst ? s2 : s4, e.sat); end
      handshake(inst, 1'b1, ok);
      checks++; if (!ok || (inst ? ir2 : ir4) !== 1'b1) begin errors++; $display("FAIL b2b_release inst=%0d tile=%0d: ok=%b ir=%b want 1 1", inst, t, ok, inst ? ir2 : ir4); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_accumulate();
    test_backpressure();
    test_reset_midfeed();
    test_back_to_back(0, 8);
    test_back_to_back(1, 12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
